// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage RISC-V pipeline,
// with a multi-cycle EX sequencer (IDLE/BUSY) and a forced-abort timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds StallCnt/FlushCnt perf counters.
module hazard_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W      = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       McStartE,
  input  logic       McDoneE,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       McTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam int unsigned CntW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  typedef enum logic [0:0] {IDLE, BUSY} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic mc_hold_c;
  logic timeout_c;
  logic lw_stall_c;
  logic branch_c;

  // Multi-cycle hold and abort conditions; normal hazards only act when the sequencer is quiet
  always_comb begin
    mc_hold_c  = McStartE & ~McDoneE;
    timeout_c  = mc_hold_c & (state_q == BUSY) & (cnt_q == CntW'(MC_TIMEOUT - 1));
    lw_stall_c = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    branch_c   = PCSrcE & (state_q == IDLE) & ~mc_hold_c;
  end

  // Sequencer state and busy-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mc_hold_c) begin
            state_q <= BUSY;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (!mc_hold_c || timeout_c) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pipeline control outputs: reset > timeout > multi-cycle hold > branch/load-use
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    McTimeout = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

      if (timeout_c) begin
        // Aborted op must not commit: bubble MEM and clear ID/EX
        McTimeout = 1'b1;
        FlushE    = 1'b1;
        FlushM    = 1'b1;
      end else if (mc_hold_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (state_q == IDLE) begin
        if (branch_c) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_stall_c) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating perf counters: stall cycles and branch/timeout flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if ((branch_c || timeout_c) && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_TIMEOUT=8).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, PCSrcE, McStartE, McDoneE, RegWriteM, RegWriteW;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McTimeout;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MC_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McTimeout(McTimeout)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,McTimeout}
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM, McTimeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; McStartE = 0; McDoneE = 0;
    RegWriteM = 0; RegWriteW = 0;
  endtask

  // Sample on the falling edge, then advance past the next rising edge
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    sample();
    chk("reset_ctl", 32'(ctl()), 32'b000_111_0);
    chk("reset_fwdA", 32'(ForwardAE), 32'd0);
    advance();
    reset = 1'b0;
    idle_in();
    sample();
    chk("idle_ctl", 32'(ctl()), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_rst", StallCnt, 32'd0);
    chk("perf_flush_rst", FlushCnt, 32'd0);
`endif
    advance();

    // Forwarding
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 6; Rs2E = 6;
    sample();
    chk("fwd_mem_A", 32'(ForwardAE), 32'b10);
    chk("fwd_wb_B", 32'(ForwardBE), 32'b01);
    RdW = 5; Rs2E = 5;
    sample();
    chk("fwd_prio_A", 32'(ForwardAE), 32'b10);
    chk("fwd_prio_B", 32'(ForwardBE), 32'b10);
    RdM = 0;
    sample();
    chk("fwd_rdm0_A", 32'(ForwardAE), 32'b01);
    RdW = 9;
    sample();
    chk("fwd_none_A", 32'(ForwardAE), 32'b00);
    RdM = 5; RegWriteM = 0; RdW = 5;
    sample();
    chk("fwd_nowrM_A", 32'(ForwardAE), 32'b01);
    RdW = 0; Rs1E = 0;
    sample();
    chk("fwd_x0_A", 32'(ForwardAE), 32'b00);
    idle_in();
    advance();

    // Load-use
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    sample();
    chk("lw_rs2", 32'(ctl()), 32'b110_010_0);
    advance();
    idle_in();
    sample();
    chk("lw_release", 32'(ctl()), 32'd0);
    advance();
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
    sample();
    chk("lw_rs1", 32'(ctl()), 32'b110_010_0);
    RdE = 0; Rs1D = 0;
    sample();
    chk("lw_rd0", 32'(ctl()), 32'd0);
    RdE = 7; Rs2D = 7; PCSrcE = 1;
    sample();
    chk("branch_beats_lw", 32'(ctl()), 32'b000_110_0);
    advance();
    idle_in();

    // Multi-cycle op, done on the 5th cycle; hazards masked while held
    McStartE = 1;
    for (int i = 1; i <= 4; i++) begin
      PCSrcE      = (i == 3);
      ResultSrcE0 = (i == 2); RdE = 7; Rs1D = 7;
      sample();
      chk($sformatf("mc_hold_%0d", i), 32'(ctl()), 32'b111_001_0);
      advance();
    end
    PCSrcE = 0; ResultSrcE0 = 0; McDoneE = 1;
    sample();
    chk("mc_done", 32'(ctl()), 32'd0);
    advance();
    idle_in();
    PCSrcE = 1;
    sample();
    chk("mc_back_idle", 32'(ctl()), 32'b000_110_0);
    advance();
    idle_in();

    // Start and done together in IDLE
    McStartE = 1; McDoneE = 1;
    sample();
    chk("mc_same_cycle", 32'(ctl()), 32'd0);
    advance();
    idle_in();
    PCSrcE = 1;
    sample();
    chk("mc_same_idle", 32'(ctl()), 32'b000_110_0);
    advance();
    idle_in();

    // Timeout: 1 IDLE hold cycle + 7 BUSY holds, abort in 8th BUSY cycle
    McStartE = 1;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk($sformatf("to_hold_%0d", i), 32'(ctl()), 32'b111_001_0);
      advance();
    end
    sample();
    chk("to_pulse", 32'(McTimeout), 32'd1);
    chk("to_flushE", 32'(FlushE), 32'd1);
    chk("to_stalls", 32'({StallF, StallD, StallE}), 32'd0);
    advance();
    idle_in();
    PCSrcE = 1;
    sample();
    chk("to_back_idle", 32'(ctl()), 32'b000_110_0);
    advance();
    idle_in();

    // Reset while BUSY: flushes only, never a timeout pulse, returns to IDLE
    McStartE = 1;
    advance();
    advance();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk($sformatf("rst_busy_%0d", i), 32'(ctl()), 32'b000_111_0);
      advance();
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_rst2", StallCnt, 32'd0);
    chk("perf_flush_rst2", FlushCnt, 32'd0);
`endif
    reset = 1'b0;
    idle_in();
    PCSrcE = 1;
    sample();
    chk("rst_back_idle", 32'(ctl()), 32'b000_110_0);
    advance();
    idle_in();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
